// File: rtl/uart_crc_tx_param.sv
// UART transmitter with a CRC-8 trailer frame appended after the last payload byte.
// Each payload byte and the trailing CRC byte go out as start, 8 data (LSB first), optional parity and stop bits.
module uart_crc_tx_param #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         PARITY       = 0,
  parameter int         STOP_BITS    = 1,
  parameter logic [7:0] CRC_POLY     = 8'h07,
  parameter logic [7:0] CRC_INIT     = 8'h00
) (
  input  logic       a,
  input  logic       b,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] crc_out,
  output logic       crc_valid
);

  localparam int             BW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_MAX = 3'(STOP_BITS - 1);
  localparam logic           ODD      = (PARITY == 2);
  localparam logic           HAS_PAR  = (PARITY != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          last_q;
  logic          crc_phase;
  logic [7:0]    crc;
  logic          accept;
  logic          bit_end;

  // MSB-first, non-reflected CRC-8 over one byte
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    return x;
  endfunction

  assign s_ready = b && (state == S_IDLE);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != S_IDLE);
  assign bit_end = (baud == BAUD_MAX);

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[0];
      S_PAR:   tx = par_bit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge a) begin
    if (!b) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      last_q    <= 1'b0;
      crc_phase <= 1'b0;
      crc       <= CRC_INIT;
      crc_out   <= 8'h00;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (state == S_IDLE) begin
        baud    <= '0;
        bit_cnt <= '0;
        if (accept) begin
          shreg   <= s_data;
          par_bit <= (^s_data) ^ ODD;
          last_q  <= s_last;
          crc     <= crc_upd(crc, s_data);
          state   <= S_START;
        end
      end else if (!bit_end) begin
        baud <= baud + 1'b1;
      end else begin
        baud <= '0;
        case (state)
          S_START: begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
          S_DATA: begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? S_PAR : S_STOP;
            end
          end
          S_PAR: begin
            bit_cnt <= '0;
            state   <= S_STOP;
          end
          S_STOP: begin
            if (bit_cnt != STOP_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              bit_cnt <= '0;
              if (crc_phase) begin
                crc_out   <= crc;
                crc_valid <= 1'b1;
                crc       <= CRC_INIT;
                crc_phase <= 1'b0;
                last_q    <= 1'b0;
                state     <= S_IDLE;
              end else if (last_q) begin
                // CRC frame follows the last payload frame with no idle gap
                shreg     <= crc;
                par_bit   <= (^crc) ^ ODD;
                crc_phase <= 1'b1;
                state     <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
